btn_irq_ctrl: RTL and testbench
===============================

# btn_irq_ctrl

Parametrised input-conditioning and interrupt-request controller for the board-level push-buttons (BTNU/BTNL/BTNR/BTND/BTNC) and external interrupt lines feeding the MIPS core's hardware interrupt inputs. Each of N_CH channels is synchronised, debounced, edge-detected according to a per-channel mode, and latched into a pending bit. Masked pending bits combine into a single `irq` line and a lowest-index channel ID. The block sits between the board pins and the core's INT inputs inside the core block design.

## Interface
- `N_CH`, 5, number of input channels (1..32)
- `DEBOUNCE_CYCLES`, 1000000, cycles an input must hold a new value before it is accepted (10 ms at 100 MHz); must be >= 1
- `CNT_W`, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden)
- `ID_W`, $clog2(N_CH) (minimum 1), width of `irq_id` (derived)

- `clk_in`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `btn_in`  in  N_CH  raw asynchronous inputs
- `edge_sel`  in  2*N_CH  per-channel mode, bits [2i+1:2i]: 00 disabled, 01 rising, 10 falling, 11 both
- `int_mask`  in  N_CH  1 = channel may drive `irq`
- `int_ack`  in  N_CH  1 = clear that channel's pending bit this cycle
- `btn_level`  out  N_CH  debounced level
- `int_pending`  out  N_CH  latched edge events
- `irq`  out  1  OR of `int_pending & int_mask`
- `irq_id`  out  ID_W  index of lowest set bit of `int_pending & int_mask`; 0 when none

## Operation
- Per channel: 2-FF synchroniser (`s1`, `s2`), debounce counter `cnt`, stable register (`btn_level`), delayed copy `lvl_d`, pending bit.
- Debounce, each edge: if `s2 == btn_level`, `cnt <= 0`. Else if `cnt == DEBOUNCE_CYCLES-1`, `btn_level <= s2`, `cnt <= 0`. Else `cnt <= cnt+1`.
- Any pulse or glitch shorter than the debounce window returns `cnt` to 0; `btn_level` is unchanged.
- Edge detect: `rise = btn_level & ~lvl_d`, `fall = ~btn_level & lvl_d`; `lvl_d <= btn_level` every cycle.
- `event_i = (edge_sel bit0 & rise) | (edge_sel bit1 & fall)`.
- Pending: `pend <= event | (pend & ~int_ack)`.
  - Set wins over ack in the same cycle.
  - Mode 00 never sets pending; bits already set stay set until acked.
  - Changing `edge_sel` never clears pending.
- Mask gates only `irq`/`irq_id`, not latching. Unmasking a channel with pending set asserts `irq` in the same cycle (combinational from registers).
- `irq`, `irq_id`: combinational from `int_pending` and `int_mask`; fixed priority, lowest index wins.

## Timing
- Reset (async assert, synchronous-release usage expected): `s1`, `s2`, `cnt`, `btn_level`, `lvl_d`, `int_pending` are all 0. Hence `btn_level`, `int_pending`, `irq`, `irq_id` are all 0.
- Input latency: `btn_in` is stable from sampling edge 1. `btn_level` changes on edge DEBOUNCE_CYCLES+2. `int_pending` sets on edge DEBOUNCE_CYCLES+3. `irq` follows `int_pending` with no added cycle.
- Ack latency: `int_ack` high at edge k means pending is 0 after edge k, unless an event occurs at edge k.
- Reset during debounce discards progress. An input held high through reset release re-debounces from 0 and produces a rising event after the full latency.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap.
- Channels are fully independent; simultaneous events on several channels all latch in the same cycle.

## Test plan
Use N_CH=5, DEBOUNCE_CYCLES=4.
- Reset, all inputs 0 -> all outputs 0; `irq_id`=0.
- Ch2: `edge_sel`=01, mask=1; `btn_in[2]` rises and is held -> `btn_level[2]`=1 after edge 6, `int_pending[2]`=1 and `irq`=1, `irq_id`=2 after edge 7. Pulse `int_ack[2]` for 1 cycle -> pending 0, `irq` 0.
- Glitch: `btn_in[0]` high for 3 cycles, then low -> `btn_level[0]` stays 0, no pending. Then high for 4+ cycles -> `btn_level[0]`=1.
- Modes: ch1=10 and ch3=11. Press and release both -> ch1 pends only on release. Ch3 pends on press; after ack, pends again on release. Ch4=00 -> never pends.
- Set vs ack: ack ch3 on the exact edge its falling event latches -> `int_pending[3]` remains 1.
- Mask/priority: channels 1 and 4 pending, mask=10000 -> `irq`=1, `irq_id`=4. Mask=11111 -> `irq_id`=1. Mask=0 -> `irq`=0 while pending stays 10010.
- Reset mid-debounce: `btn_in[2]` high, assert `reset` at cycle 3 -> all cleared. After release with the input still high -> `btn_level[2]` rises 6 edges later and pending sets (rising mode).

Source files
------------

// File: rtl/btn_irq_ctrl.sv
// btn_irq_ctrl
// Conditions the board push-buttons and external interrupt lines for the
// core's hardware interrupt inputs. Each channel is synchronised, debounced,
// edge-detected according to its mode, and latched into a pending bit.
// Masked pending bits form a single irq line and a lowest-index channel id.
//
// Ports:
//   clk_in       system clock, all state on the rising edge
//   reset        asynchronous, active-high reset
//   btn_in       raw asynchronous inputs, one per channel
//   edge_sel     per-channel mode, bits [2i+1:2i]:
//                00 disabled, 01 rising, 10 falling, 11 both
//   int_mask     1 = channel may drive irq / irq_id
//   int_ack      1 = clear that channel's pending bit this cycle
//   btn_level    debounced level
//   int_pending  latched edge events
//   irq          OR of int_pending & int_mask
//   irq_id       index of lowest set bit of int_pending & int_mask, 0 if none
module btn_irq_ctrl #(
    parameter int N_CH            = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1),
    localparam int ID_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [N_CH-1:0]     btn_in,
    input  logic [2*N_CH-1:0]   edge_sel,
    input  logic [N_CH-1:0]     int_mask,
    input  logic [N_CH-1:0]     int_ack,
    output logic [N_CH-1:0]     btn_level,
    output logic [N_CH-1:0]     int_pending,
    output logic                irq,
    output logic [ID_W-1:0]     irq_id
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0]  s1;
    logic [N_CH-1:0]  s2;
    logic [CNT_W-1:0] cnt [N_CH];
    logic [N_CH-1:0]  lvl_d;
    logic [N_CH-1:0]  rise;
    logic [N_CH-1:0]  fall;
    logic [N_CH-1:0]  evt;
    logic [N_CH-1:0]  masked;

    // Stage: two-flop synchroniser for the asynchronous pins
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    // Stage: debounce. The counter only runs while the synchronised input
    // disagrees with the accepted level; any agreement restarts the window,
    // so glitches shorter than DEBOUNCE_CYCLES never reach btn_level.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            btn_level <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (s2[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    btn_level[i] <= s2[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rise = btn_level & ~lvl_d;
        fall = ~btn_level & lvl_d;
        evt  = '0;
        for (int i = 0; i < N_CH; i++) begin
            evt[i] = (edge_sel[2*i] & rise[i]) | (edge_sel[2*i+1] & fall[i]);
        end
    end

    // Stage: edge history and pending latch. A new event wins over an ack
    // arriving on the same edge so no edge is ever lost.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            lvl_d       <= '0;
            int_pending <= '0;
        end else begin
            lvl_d       <= btn_level;
            int_pending <= evt | (int_pending & ~int_ack);
        end
    end

    // Mask only gates the request, never the latching, so unmasking a
    // channel with a stored event raises irq immediately.
    always_comb begin
        masked = int_pending & int_mask;
        irq    = |masked;
        irq_id = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (masked[i]) begin
                irq_id = ID_W'(i);
            end
        end
    end

endmodule

// File: tb/tb_btn_irq_ctrl.sv
module tb_btn_irq_ctrl;

    localparam int N   = 5;
    localparam int D   = 4;
    localparam int IDW = 3;

    logic            clk_in = 1'b0;
    logic            reset;
    logic [N-1:0]    btn_in;
    logic [2*N-1:0]  edge_sel;
    logic [N-1:0]    int_mask;
    logic [N-1:0]    int_ack;
    logic [N-1:0]    btn_level;
    logic [N-1:0]    int_pending;
    logic            irq;
    logic [IDW-1:0]  irq_id;

    int checks   = 0;
    int failures = 0;

    btn_irq_ctrl #(
        .N_CH            (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .btn_in      (btn_in),
        .edge_sel    (edge_sel),
        .int_mask    (int_mask),
        .int_ack     (int_ack),
        .btn_level   (btn_level),
        .int_pending (int_pending),
        .irq         (irq),
        .irq_id      (irq_id)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: the level seen after synchronisation is the pin value
    // from two edges ago; the accepted level flips once the last D of those
    // values all disagree with it. An accepted change is reported as an event
    // one edge later.
    logic [N-1:0] smp [$];
    logic [N-1:0] s2q [$];
    logic [N-1:0] m_lvl, m_pend, m_rose, m_fell;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        smp.delete();
        s2q.delete();
        m_lvl  = '0;
        m_pend = '0;
        m_rose = '0;
        m_fell = '0;
    endtask

    task automatic model_edge();
        logic [N-1:0] s2v, ev, nrose, nfell;
        bit all_diff;
        s2v = (smp.size() >= 2) ? smp[0] : '0;
        smp.push_back(btn_in);
        if (smp.size() > 2) void'(smp.pop_front());
        s2q.push_back(s2v);
        if (s2q.size() > D) void'(s2q.pop_front());
        ev = '0;
        for (int i = 0; i < N; i++)
            ev[i] = (edge_sel[2*i] & m_rose[i]) | (edge_sel[2*i+1] & m_fell[i]);
        m_pend = ev | (m_pend & ~int_ack);
        nrose = '0;
        nfell = '0;
        for (int i = 0; i < N; i++) begin
            all_diff = (s2q.size() == D);
            foreach (s2q[k]) if (s2q[k][i] == m_lvl[i]) all_diff = 0;
            if (all_diff) begin
                if (m_lvl[i]) nfell[i] = 1'b1;
                else          nrose[i] = 1'b1;
            end
        end
        m_rose = nrose;
        m_fell = nfell;
        m_lvl  = m_lvl ^ (nrose | nfell);
    endtask

    task automatic compare();
        logic [N-1:0] mm, low;
        int id;
        mm  = m_pend & int_mask;
        low = mm & (~mm + 5'd1);
        id  = (mm == 0) ? 0 : $clog2(low);
        chk("btn_level",   32'(btn_level),   32'(m_lvl));
        chk("int_pending", 32'(int_pending), 32'(m_pend));
        chk("irq",         32'(irq),         32'(mm != 0));
        chk("irq_id",      32'(irq_id),      32'(id));
    endtask

    // One rising edge: model follows the inputs present at the edge, then
    // outputs are compared 1 ns later.
    task automatic step();
        @(posedge clk_in);
        if (!reset) model_edge();
        #1;
        compare();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic async_rst();
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        chk("rst_level", 32'(btn_level),   32'd0);
        chk("rst_pend",  32'(int_pending), 32'd0);
        chk("rst_irq",   32'(irq),         32'd0);
        compare();
        steps(2);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        btn_in   = '0;
        edge_sel = '0;
        int_mask = '0;
        int_ack  = '0;
        model_clear();
        #12;
        chk("reset_level", 32'(btn_level),   32'd0);
        chk("reset_pend",  32'(int_pending), 32'd0);
        chk("reset_irq",   32'(irq),         32'd0);
        chk("reset_id",    32'(irq_id),      32'd0);
        reset = 1'b0;
        step();

        // Channel 2 rising mode, full latency and ack
        edge_sel = 10'b00_00_01_00_00;
        int_mask = 5'b11111;
        btn_in[2] = 1'b1;
        steps(5);
        chk("ch2_lvl_e5", 32'(btn_level[2]), 32'd0);
        step();
        chk("ch2_lvl_e6", 32'(btn_level[2]), 32'd1);
        chk("ch2_pend_e6", 32'(int_pending[2]), 32'd0);
        step();
        chk("ch2_pend_e7", 32'(int_pending[2]), 32'd1);
        chk("ch2_irq_e7",  32'(irq),    32'd1);
        chk("ch2_id_e7",   32'(irq_id), 32'd2);
        int_ack[2] = 1'b1;
        step();
        int_ack = '0;
        chk("ch2_ack_pend", 32'(int_pending[2]), 32'd0);
        chk("ch2_ack_irq",  32'(irq), 32'd0);
        btn_in[2] = 1'b0;
        steps(8);

        // Glitch on channel 0, then a real press
        btn_in[0] = 1'b1;
        steps(3);
        btn_in[0] = 1'b0;
        steps(8);
        chk("glitch_lvl",  32'(btn_level[0]),   32'd0);
        chk("glitch_pend", 32'(int_pending[0]), 32'd0);
        btn_in[0] = 1'b1;
        steps(8);
        chk("press_lvl0", 32'(btn_level[0]), 32'd1);

        // Modes: ch1 falling, ch3 both, ch4 disabled
        edge_sel = 10'b00_11_01_10_00;
        btn_in[1] = 1'b1;
        btn_in[3] = 1'b1;
        btn_in[4] = 1'b1;
        steps(8);
        chk("mode_ch3_press", 32'(int_pending[3]), 32'd1);
        chk("mode_ch1_press", 32'(int_pending[1]), 32'd0);
        chk("mode_ch4_press", 32'(int_pending[4]), 32'd0);
        int_ack[3] = 1'b1;
        step();
        int_ack = '0;
        btn_in[1] = 1'b0;
        btn_in[3] = 1'b0;
        btn_in[4] = 1'b0;
        steps(6);
        // Ack lands on the edge where the falling event latches
        int_ack[3] = 1'b1;
        step();
        int_ack = '0;
        chk("set_wins_ack", 32'(int_pending[3]), 32'd1);
        chk("mode_ch1_rel", 32'(int_pending[1]), 32'd1);
        chk("mode_ch4_rel", 32'(int_pending[4]), 32'd0);
        steps(2);

        // Give ch4 a rising event, clear ch3 -> pending 10010
        edge_sel = 10'b01_11_01_10_00;
        btn_in[4] = 1'b1;
        int_ack[3] = 1'b1;
        step();
        int_ack = '0;
        steps(8);
        chk("pend_10010", 32'(int_pending), 32'b10010);
        int_mask = 5'b10000;
        #1;
        chk("mask_hi_irq", 32'(irq),    32'd1);
        chk("mask_hi_id",  32'(irq_id), 32'd4);
        int_mask = 5'b11111;
        #1;
        chk("mask_all_id", 32'(irq_id), 32'd1);
        int_mask = 5'b00000;
        #1;
        chk("mask_none_irq",  32'(irq),         32'd0);
        chk("mask_none_pend", 32'(int_pending), 32'b10010);
        int_mask = 5'b11111;
        int_ack  = 5'b11111;
        step();
        int_ack  = '0;

        // Reset during debounce; input stays high through release
        btn_in   = 5'b00100;
        edge_sel = 10'b00_00_01_00_00;
        steps(3);
        async_rst();
        steps(5);
        chk("rst_ch2_lvl_e5", 32'(btn_level[2]), 32'd0);
        step();
        chk("rst_ch2_lvl_e6", 32'(btn_level[2]), 32'd1);
        step();
        chk("rst_ch2_pend_e7", 32'(int_pending[2]), 32'd1);

        // Randomised phase against the model
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) btn_in[i] = ~btn_in[i];
            int_ack = '0;
            for (int i = 0; i < N; i++)
                if ($urandom_range(3) == 0) int_ack[i] = 1'b1;
            if ($urandom_range(49) == 0) edge_sel = 10'($urandom);
            if ($urandom_range(9) == 0) begin
                int_mask = 5'($urandom);
                #1;
                compare();
            end
            if ($urandom_range(599) == 0) async_rst();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
